// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: fetch reset vector and 2-bit branch counter encodings
package if_fetch_unit_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_t;
    function automatic cnt_t cnt_next(input cnt_t c, input logic taken);
        return taken ? (c == ST ? ST : cnt_t'(c + 2'd1)) : (c == SNT ? SNT : cnt_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/if_fetch_unit_btb_2bit.sv
// btb_2bit: direct-mapped branch target buffer with 2-bit saturating direction counters
module btb_2bit
    import if_fetch_unit_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lk_pc,
    output logic        pre,
    output logic [31:0] target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int N  = 1 << IDX_W;
    localparam int TW = 30 - IDX_W;
    logic              valid [N];
    logic [TW-1:0]     tag   [N];
    logic [31:0]       tgt   [N];
    cnt_t              cnt   [N];
    logic [IDX_W-1:0]  li, ui;
    logic              u_hit;
    logic              unused_low;
    assign unused_low = ^{lk_pc[1:0], upd_pc[1:0]};
    assign li     = lk_pc[IDX_W+1:2];
    assign ui     = upd_pc[IDX_W+1:2];
    assign pre    = valid[li] && tag[li] == lk_pc[31:IDX_W+2] && cnt[li][1];
    assign target = tgt[li];
    assign u_hit  = valid[ui] && tag[ui] == upd_pc[31:IDX_W+2];
    // Writes land on the edge, so a same-cycle lookup always sees the old entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid[i] <= 1'b0;
                tag[i]   <= '0;
                tgt[i]   <= '0;
                cnt[i]   <= WNT;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                cnt[ui] <= cnt_next(cnt[ui], upd_taken);
                if (upd_taken) tgt[ui] <= upd_target;
            end else if (upd_taken) begin
                valid[ui] <= 1'b1;
                tag[ui]   <= upd_pc[31:IDX_W+2];
                tgt[ui]   <= upd_target;
                cnt[ui]   <= WT;
            end
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, BTB-predicted next-PC selection and stall/flush handling
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = if_fetch_unit_pkg::RESET_PC,
    parameter int          BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wEn,
    input  logic        Flush,
    input  logic [31:0] redirect_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_pcadd4,
    output logic        pre
);
    logic [31:0] pc, btb_target, pred_next;
    btb_2bit #(.IDX_W(BTB_IDX_W)) u_btb (
        .clk        (clk),
        .rst        (rst),
        .lk_pc      (pc),
        .pre        (pre),
        .target     (btb_target),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );
    assign imem_addr = pc;
    assign IF_pc     = pc;
    assign IF_instr  = imem_rdata;
    assign IF_pcadd4 = pc + 32'd4;
    assign pred_next = pre ? btb_target : IF_pcadd4;
    // A flush overrides a stall: the mispredicted path must be abandoned now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else if (Flush) pc <= redirect_pc & 32'hFFFF_FFFC;
        else if (wEn) pc <= pred_next & 32'hFFFF_FFFC;
    end
endmodule
